// File: rtl/ro_scan_ctrl.sv
// Ring-oscillator scan sequencer.
// Walks RO 0..NUM_RO-1: enables one RO, lets it settle, counts clk cycles
// across PERIOD rising RO edges (or gives up after TIMEOUT_CYC cycles) and
// writes the count to the result RAM at the RO index.
// i_start is a single-cycle request honoured only in IDLE; o_done is a
// single-cycle completion pulse; o_ram_we is a single-cycle write strobe
// qualifying o_ram_addr/o_ram_wdata (both forced to 0 when the strobe is low).
// o_state exposes the FSM encoding for observation.
module ro_scan_ctrl #(
    parameter int NUM_RO      = 16,
    parameter int IDX_W       = 4,
    parameter int PERIOD      = 2048,
    parameter int SETTLE_CYC  = 64,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [NUM_RO-1:0] i_ro_in,
    output logic [NUM_RO-1:0] o_ro_en,
    output logic              o_ram_we,
    output logic [IDX_W-1:0]  o_ram_addr,
    output logic [31:0]       o_ram_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [NUM_RO-1:0] o_err_mask,
    output logic [2:0]        o_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_ARM    = 3'd2,
        S_MEAS   = 3'd3,
        S_STORE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [31:0] SAT = 32'hFFFF_FFFF;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_idx;
    logic              r_s1, r_s2, r_s3;
    logic [31:0]       r_settle_cnt;
    logic [31:0]       r_tout_cnt;
    logic [31:0]       r_clk_cnt;
    logic [31:0]       r_edge_cnt;
    logic [31:0]       r_wdata;
    logic [NUM_RO-1:0] r_err;

    logic              w_edge;
    logic              w_settle_done;
    logic              w_tout;
    logic              w_final;
    logic [31:0]       w_clk_inc;
    logic [NUM_RO-1:0] w_onehot;
    logic              w_switch;
    logic              w_clr_err;
    logic              w_idx_inc;
    logic              w_capture;
    logic              w_timeout;

    // Edge detect on the synchronised sample of the selected RO.
    assign w_edge        = r_s2 & ~r_s3;
    assign w_settle_done = (r_settle_cnt == 32'(SETTLE_CYC - 1));
    assign w_tout        = (r_tout_cnt >= 32'(TIMEOUT_CYC - 1));
    assign w_final       = w_edge && (r_edge_cnt == 32'(PERIOD - 1));
    // Count stored includes the cycle carrying the final edge; never wraps.
    assign w_clk_inc     = (r_clk_cnt == SAT) ? SAT : r_clk_cnt + 32'd1;
    assign w_onehot      = {{(NUM_RO-1){1'b0}}, 1'b1} << r_idx;

    assign o_err_mask = r_err;
    assign o_state    = r_state;

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode, outputs and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        o_ro_en     = '0;
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        w_switch    = 1'b0;
        w_clr_err   = 1'b0;
        w_idx_inc   = 1'b0;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_SETTLE;
                    w_switch    = 1'b1;
                    w_clr_err   = 1'b1;
                end
            end
            S_SETTLE: begin
                o_busy  = 1'b1;
                o_ro_en = w_onehot;
                if (w_settle_done) begin
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                o_busy  = 1'b1;
                o_ro_en = w_onehot;
                if (w_tout) begin
                    w_state_nxt = S_STORE;
                    w_timeout   = 1'b1;
                end else if (w_edge) begin
                    w_state_nxt = S_MEAS;
                end
            end
            S_MEAS: begin
                o_busy  = 1'b1;
                o_ro_en = w_onehot;
                // A final edge coinciding with the timeout still yields a valid count.
                if (w_final) begin
                    w_state_nxt = S_STORE;
                    w_capture   = 1'b1;
                end else if (w_tout) begin
                    w_state_nxt = S_STORE;
                    w_timeout   = 1'b1;
                end
            end
            S_STORE: begin
                o_busy      = 1'b1;
                o_ram_we    = 1'b1;
                o_ram_addr  = r_idx;
                o_ram_wdata = r_wdata;
                if (r_idx == IDX_W'(NUM_RO - 1)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_SETTLE;
                    w_switch    = 1'b1;
                    w_idx_inc   = 1'b1;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Measurement datapath: synchroniser, counters, result and error latches.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_idx        <= '0;
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_settle_cnt <= '0;
            r_tout_cnt   <= '0;
            r_clk_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_wdata      <= '0;
            r_err        <= '0;
        end else begin
            // Flush the synchroniser whenever a different RO is selected so a
            // stale level from the previous RO cannot produce a false edge.
            if (w_switch) begin
                r_s1 <= 1'b0;
                r_s2 <= 1'b0;
                r_s3 <= 1'b0;
            end else begin
                r_s1 <= i_ro_in[r_idx];
                r_s2 <= r_s1;
                r_s3 <= r_s2;
            end

            r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + 32'd1 : '0;

            if ((r_state == S_ARM) || (r_state == S_MEAS)) begin
                r_tout_cnt <= (r_tout_cnt == SAT) ? SAT : r_tout_cnt + 32'd1;
            end else begin
                r_tout_cnt <= '0;
            end

            // Edge 0 is seen in ARM; MEAS then starts from zero counts.
            if (r_state == S_MEAS) begin
                r_clk_cnt <= w_clk_inc;
                if (w_edge && (r_edge_cnt != SAT)) begin
                    r_edge_cnt <= r_edge_cnt + 32'd1;
                end
            end else begin
                r_clk_cnt  <= '0;
                r_edge_cnt <= '0;
            end

            if (w_capture) begin
                r_wdata <= w_clk_inc;
            end else if (w_timeout) begin
                r_wdata <= SAT;
            end

            if (w_clr_err) begin
                r_err <= '0;
            end else if (w_timeout) begin
                r_err[r_idx] <= 1'b1;
            end

            if (r_state == S_IDLE) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ro_scan_ctrl.sv
// Bench for ro_scan_ctrl. Four instances with different PERIOD/TIMEOUT_CYC
// share one reset; the instance under test is selected by 'cur'. Each RO model
// oscillates only while its enable is high, starting from a fixed phase, so
// window lengths are exactly predictable.
module tb_ro_scan_ctrl;

    localparam int NUM_RO = 16;
    localparam int IDX_W  = 4;
    localparam int SETTLE = 8;
    localparam int NI     = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NI-1:0]     start;
    logic [NUM_RO-1:0] ro_in  [NI];
    logic [NUM_RO-1:0] ro_en  [NI];
    logic [NI-1:0]     we;
    logic [IDX_W-1:0]  addr   [NI];
    logic [31:0]       wdata  [NI];
    logic [NI-1:0]     busy;
    logic [NI-1:0]     done;
    logic [NUM_RO-1:0] err    [NI];
    logic [2:0]        st     [NI];

    // Instance 0: PERIOD 8, timeout 200. Instance 1: PERIOD 1.
    // Instance 2: timeout lands on the final edge. Instance 3: one cycle earlier.
    for (genvar g = 0; g < NI; g++) begin : g_dut
        ro_scan_ctrl #(
            .NUM_RO     (NUM_RO),
            .IDX_W      (IDX_W),
            .PERIOD     ((g == 1) ? 1 : 8),
            .SETTLE_CYC (SETTLE),
            .TIMEOUT_CYC((g == 2) ? 36 : ((g == 3) ? 35 : 200))
        ) u_dut (
            .i_clk      (clk),
            .i_rst      (rst),
            .i_start    (start[g]),
            .i_ro_in    (ro_in[g]),
            .o_ro_en    (ro_en[g]),
            .o_ram_we   (we[g]),
            .o_ram_addr (addr[g]),
            .o_ram_wdata(wdata[g]),
            .o_busy     (busy[g]),
            .o_done     (done[g]),
            .o_err_mask (err[g]),
            .o_state    (st[g])
        );
    end

    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          done_cnt = 0;
    int          cur      = 0;
    int          div      = 4;
    logic [15:0] stuck    = '0;
    int          ph [NI][NUM_RO];
    logic [35:0] exp_q[$];
    logic [35:0] m_exp;
    logic [15:0] m_oh;

    // RO models: period 'div' clk cycles while enabled, held low otherwise.
    always @(negedge clk) begin
        for (int g = 0; g < NI; g++) begin
            for (int k = 0; k < NUM_RO; k++) begin
                if (ro_en[g][k] === 1'b1) ph[g][k] = (ph[g][k] + 1) % div;
                else                      ph[g][k] = 0;
                ro_in[g][k] = !stuck[k] && (ph[g][k] >= div / 2);
            end
        end
    end

    // Scoreboard: pop on every write; between writes the enable must be the
    // one-hot of the next expected address.
    always @(negedge clk) begin
        if (rst) begin
            if (done[cur] === 1'b1) done_cnt++;
            if (we[cur] === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", addr[cur], wdata[cur]);
                end else begin
                    m_exp = exp_q.pop_front();
                    if ({addr[cur], wdata[cur]} !== m_exp || ro_en[cur] !== 16'h0) begin
                        n_bad++;
                        $display("FAIL ram_write: got addr=%0d data=%h ro_en=%h, required addr=%0d data=%h ro_en=0000",
                                 addr[cur], wdata[cur], ro_en[cur], m_exp[35:32], m_exp[31:0]);
                    end
                end
            end else if (busy[cur] === 1'b1 && exp_q.size() > 0) begin
                n_cmp++;
                m_oh = 16'h0001 << exp_q[0][35:32];
                if (ro_en[cur] !== m_oh) begin
                    n_bad++;
                    $display("FAIL ro_en_onehot: got %h, required %h", ro_en[cur], m_oh);
                end
            end
        end
    end

    task automatic pulse_start(input int g);
        @(negedge clk); start[g] = 1'b1;
        @(negedge clk); start[g] = 1'b0;
    endtask

    task automatic push_scan(input logic [31:0] d, input logic [15:0] tmask);
        for (int k = 0; k < NUM_RO; k++) exp_q.push_back({4'(k), tmask[k] ? 32'hFFFF_FFFF : d});
    endtask

    task automatic wait_done(input int g, input int budget);
        int n = 0;
        while (done[g] !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (done[g] !== 1'b1) begin
            n_bad++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            n_cmp++;
            if ({ro_en[g], we[g], addr[g], wdata[g], busy[g], done[g], err[g], st[g]} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs: inst %0d got ro_en=%h we=%b wdata=%h busy=%b err=%h, required all 0",
                         g, ro_en[g], we[g], wdata[g], busy[g], err[g]);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_nominal;
        cur = 0; done_cnt = 0; div = 4; stuck = '0;
        push_scan(32'd32, 16'h0);
        pulse_start(0);
        n_cmp++;
        if (busy[0] !== 1'b1) begin n_bad++; $display("FAIL busy_after_start: got %b, required 1", busy[0]); end
        wait_done(0, 5000);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || done_cnt != 1 || err[0] !== 16'h0 || busy[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL nominal_end: got left=%0d dones=%0d err=%h busy=%b, required 0/1/0000/0",
                     exp_q.size(), done_cnt, err[0], busy[0]);
        end
    endtask

    task automatic test_timeout;
        cur = 0; done_cnt = 0; div = 4; stuck = 16'h0008;
        push_scan(32'd32, 16'h0008);
        pulse_start(0);
        wait_done(0, 6000);
        repeat (3) @(negedge clk);
        stuck = '0;
        n_cmp++;
        if (exp_q.size() != 0 || done_cnt != 1 || err[0] !== 16'h0008) begin
            n_bad++;
            $display("FAIL timeout_end: got left=%0d dones=%0d err=%h, required 0/1/0008",
                     exp_q.size(), done_cnt, err[0]);
        end
    endtask

    task automatic test_back_to_back;
        cur = 0; done_cnt = 0; div = 4; stuck = '0;
        push_scan(32'd32, 16'h0);
        pulse_start(0);
        repeat (100) @(negedge clk);
        pulse_start(0);
        repeat (300) @(negedge clk);
        pulse_start(0);
        wait_done(0, 5000);
        // Request in the DONE cycle must be dropped.
        start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b0 || st[0] !== 3'd0) begin
            n_bad++;
            $display("FAIL start_in_done: got busy=%b state=%0d, required busy=0 state=0", busy[0], st[0]);
        end
        n_cmp++;
        if (exp_q.size() != 0 || done_cnt != 1) begin
            n_bad++;
            $display("FAIL back_to_back_end: got left=%0d dones=%0d, required 0/1", exp_q.size(), done_cnt);
        end
    endtask

    task automatic test_reset_abort;
        int n = 0;
        cur = 0; done_cnt = 0; div = 4; stuck = '0;
        push_scan(32'd32, 16'h0);
        pulse_start(0);
        while (exp_q.size() > 11 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (st[0] !== 3'd3 || exp_q.size() != 11) begin
            n_bad++;
            $display("FAIL abort_point: got state=%0d left=%0d, required state=3 left=11", st[0], exp_q.size());
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ro_en[0], we[0], addr[0], wdata[0], busy[0], done[0], err[0], st[0]} !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: got ro_en=%h we=%b wdata=%h busy=%b state=%0d, required all 0",
                     ro_en[0], we[0], wdata[0], busy[0], st[0]);
        end
        rst = 1'b1;
        exp_q.delete();
        repeat (200) @(negedge clk);
        n_cmp++;
        if (busy[0] !== 1'b0 || done_cnt != 0) begin
            n_bad++;
            $display("FAIL abort_idle: got busy=%b dones=%0d, required 0/0", busy[0], done_cnt);
        end
        push_scan(32'd32, 16'h0);
        pulse_start(0);
        wait_done(0, 5000);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || done_cnt != 1 || err[0] !== 16'h0) begin
            n_bad++;
            $display("FAIL restart_end: got left=%0d dones=%0d err=%h, required 0/1/0000",
                     exp_q.size(), done_cnt, err[0]);
        end
    endtask

    task automatic test_div6;
        cur = 1; done_cnt = 0; div = 6; stuck = '0;
        push_scan(32'd6, 16'h0);
        pulse_start(1);
        wait_done(1, 3000);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || done_cnt != 1 || err[1] !== 16'h0) begin
            n_bad++;
            $display("FAIL div6_end: got left=%0d dones=%0d err=%h, required 0/1/0000",
                     exp_q.size(), done_cnt, err[1]);
        end
    endtask

    task automatic test_coincide;
        cur = 2; done_cnt = 0; div = 4; stuck = '0;
        push_scan(32'd32, 16'h0);
        pulse_start(2);
        wait_done(2, 3000);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || done_cnt != 1 || err[2] !== 16'h0) begin
            n_bad++;
            $display("FAIL coincide_end: got left=%0d dones=%0d err=%h, required 0/1/0000",
                     exp_q.size(), done_cnt, err[2]);
        end
        cur = 3; done_cnt = 0;
        push_scan(32'd32, 16'hFFFF);
        pulse_start(3);
        wait_done(3, 3000);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0 || done_cnt != 1 || err[3] !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL early_timeout_end: got left=%0d dones=%0d err=%h, required 0/1/ffff",
                     exp_q.size(), done_cnt, err[3]);
        end
    endtask

    initial begin
        rst   = 1'b0;
        start = '0;
        for (int g = 0; g < NI; g++) ro_in[g] = '0;
        test_reset;
        test_nominal;
        test_timeout;
        test_back_to_back;
        test_reset_abort;
        test_div6;
        test_coincide;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
